// File: rtl/asat_arb_pkg.sv
// Shared types for the round-robin adder arbiter: response and tag records.
// Struct widths follow ASAT_NUM_REQ/ASAT_DW; keep them equal to the top's NUM_REQ/DW.
package asat_arb_pkg;

  localparam int ASAT_NUM_REQ = 4;
  localparam int ASAT_DW      = 32;
  localparam int ID_W         = (ASAT_NUM_REQ > 1) ? $clog2(ASAT_NUM_REQ) : 1;

  typedef struct packed {
    logic [ID_W-1:0]           id;
    logic signed [ASAT_DW-1:0] sum;
  } rsp_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int n);
    return (int'(id) + 1 >= n) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/asat_rsp_fifo.sv
// Response FIFO with registered head/valid; the head entry never changes while
// it is presented and not popped.
module asat_rsp_fifo
  import asat_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  rsp_t                       push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       valid_o,
  output rsp_t                       head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH-1) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
  assign cnt_d   = cnt_q + CW'(push_i) - CW'(do_pop);
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_o <= (cnt_d != '0);
      // The next head may be the entry being written this very cycle.
      if (cnt_d != '0) begin
        if (push_i && (wr_q == rd_d)) head_o <= push_data_i;
        else                          head_o <= mem_q[rd_d];
      end
    end
  end

endmodule

// File: rtl/asat_adder_arbiter.sv
// Round-robin sharing of one external pipelined 3-input adder among NUM_REQ requesters.
// Optional macro ASAT_ARB_STATS_EN adds saturating grant/stall counters.
module asat_adder_arbiter
  import asat_arb_pkg::*;
#(
  parameter int NUM_REQ    = ASAT_NUM_REQ,
  parameter int DW         = ASAT_DW,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  input  logic [NUM_REQ*DW-1:0] req_c,
  output logic signed [DW-1:0]  add_a,
  output logic signed [DW-1:0]  add_b,
  output logic signed [DW-1:0]  add_c,
  output logic                  add_rst,
  input  logic signed [DW-1:0]  add_s,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic signed [DW-1:0]  rsp_sum
`ifdef ASAT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grants,
  output logic [15:0]           stat_stall
`endif
);

  localparam int CW = 8;

  logic signed [DW-1:0] a_arr [NUM_REQ];
  logic signed [DW-1:0] b_arr [NUM_REQ];
  logic signed [DW-1:0] c_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DW +: DW];
    assign b_arr[g] = req_b[g*DW +: DW];
    assign c_arr[g] = req_c[g*DW +: DW];
  end

  // Stage 0 is aligned with the add_* operand registers, stage ADD_LAT with add_s.
  tag_t                            tag_p_q [ADD_LAT+1];
  logic [ID_W-1:0]                 rr_q, win_id, idx;
  logic                            found, credit_ok, issue, pop, push;
  logic [CW-1:0]                   inflight;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt;
  rsp_t                            push_data, head;

  assign add_rst = rst;
  assign pop     = rsp_valid & rsp_ready;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k <= ADD_LAT; k++) begin
      inflight = inflight + CW'(tag_p_q[k].vld);
    end
  end

  // A pop in the same cycle frees the slot the new issue will eventually need.
  assign credit_ok = (inflight + CW'(fifo_cnt) + CW'(1)) <= (CW'(FIFO_DEPTH) + CW'(pop));
  assign issue     = !rst && found && credit_ok;
  assign req_ready = issue ? (NUM_REQ'(1) << win_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      add_a <= '0;
      add_b <= '0;
      add_c <= '0;
      for (int k = 0; k <= ADD_LAT; k++) tag_p_q[k] <= '0;
    end else begin
      if (issue) begin
        add_a <= a_arr[win_id];
        add_b <= b_arr[win_id];
        add_c <= c_arr[win_id];
        rr_q  <= rr_next(win_id, NUM_REQ);
      end
      tag_p_q[0] <= '{vld: issue, id: win_id};
      for (int k = 1; k <= ADD_LAT; k++) tag_p_q[k] <= tag_p_q[k-1];
    end
  end

  // ---- result capture ----
  assign push      = tag_p_q[ADD_LAT].vld;
  assign push_data = '{id: tag_p_q[ADD_LAT].id, sum: add_s};

  asat_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_cnt),
    .valid_o     (rsp_valid),
    .head_o      (head)
  );

  assign rsp_id  = head.id;
  assign rsp_sum = head.sum;

`ifdef ASAT_ARB_STATS_EN
  logic [15:0] grant_q [NUM_REQ];
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_q[i] <= '0;
      stall_q <= '0;
    end else begin
      if (issue) grant_q[win_id] <= sat_inc16(grant_q[win_id]);
      if ((|req_valid) && !credit_ok) stall_q <= sat_inc16(stall_q);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_asat_adder_arbiter.sv
// Bench for asat_adder_arbiter: directed table, multi-cycle corner sequences and
// randomized traffic against a queue-based reference model.
module tb_asat_adder_arbiter;
  import asat_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_ready;
  logic [N*DW-1:0]      req_a, req_b, req_c;
  logic signed [DW-1:0] add_a, add_b, add_c, add_s;
  logic                 add_rst, rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic signed [DW-1:0] rsp_sum;
`ifdef ASAT_ARB_STATS_EN
  logic [N*16-1:0]      stat_grants;
  logic [15:0]          stat_stall;
`endif

  logic signed [DW-1:0] ta [N];
  logic signed [DW-1:0] tb [N];
  logic signed [DW-1:0] tc [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*DW +: DW] = ta[g];
    assign req_b[g*DW +: DW] = tb[g];
    assign req_c[g*DW +: DW] = tc[g];
  end

  always #5 clk = ~clk;

  asat_adder_arbiter #(
    .NUM_REQ    (N),
    .DW         (DW),
    .ADD_LAT    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c),
    .add_rst    (add_rst),
    .add_s      (add_s),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum)
`ifdef ASAT_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  // Stand-in for the shared adder: LAT register stages after the operand registers.
  logic signed [DW-1:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= add_a + add_b + add_c;
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_s = apipe[LAT-1];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: ordered list of expected responses with their earliest visible cycle.
  typedef struct {
    int                   id;
    logic signed [DW-1:0] sum;
    int                   due;
  } exp_t;

  exp_t mq[$];
  int   m_out = 0;
  int   m_rr  = 0;
  int   cyc   = 0;

  // Independent observation of DUT handshakes.
  int hs_cnt = 0;
  int hs_ids[$];
  int pop_ids[$];
  int pop_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_cnt++;
          hs_ids.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        pop_ids.push_back(int'(rsp_id));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    logic [N-1:0]         exp_rdy;
    bit                   exp_vld, pop;
    int                   w;
    logic signed [DW-1:0] s;
    @(negedge clk);
    exp_rdy = '0;
    exp_vld = 1'b0;
    pop     = 1'b0;
    w       = -1;
    s       = '0;
    check("add_rst", 64'(add_rst), 64'(rst));
    if (rst) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
    end else begin
      exp_vld = (mq.size() > 0) && (cyc >= mq[0].due);
      check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
      if (exp_vld && rsp_valid) begin
        check("rsp_id", 64'(rsp_id), 64'(mq[0].id));
        check("rsp_sum", 64'(rsp_sum), 64'(mq[0].sum));
      end
      pop = exp_vld && rsp_ready;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req_valid[(m_rr + i) % N]) w = (m_rr + i) % N;
      end
      if (w >= 0 && (m_out + 1 <= DEPTH + (pop ? 1 : 0))) begin
        exp_rdy[w] = 1'b1;
        s = ta[w] + tb[w] + tc[w];
      end else begin
        w = -1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_out = 0;
      m_rr  = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_out--;
      end
      if (w >= 0) begin
        mq.push_back('{id: w, sum: s, due: cyc + LAT + 1});
        m_out++;
        m_rr = (w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    int                   id;
    logic signed [DW-1:0] a, b, c, s;
  } vec_t;

  vec_t tbl[6];
  int   k, h0, p0;

  initial begin
    tbl[0] = '{0, 32'sd5, -32'sd3, 32'sd10, 32'sd12};
    tbl[1] = '{1, 32'sh7FFFFFFF, 32'sd1, 32'sd0, 32'sh80000000};
    tbl[2] = '{2, -32'sd100, -32'sd100, -32'sd100, -32'sd300};
    tbl[3] = '{3, 32'sh80000000, -32'sd1, 32'sd0, 32'sh7FFFFFFF};
    tbl[0+4] = '{0, -32'sd1, -32'sd1, 32'sd2, 32'sd0};
    tbl[5] = '{2, 32'sd1234, 32'sd0, -32'sd34, 32'sd1200};

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0; tb[i] = '0; tc[i] = '0;
    end
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_add_a", 64'(add_a), 64'(0));
    check("rst_add_b", 64'(add_b), 64'(0));
    check("rst_add_c", 64'(add_c), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_sum", 64'(rsp_sum), 64'(0));

    // Directed single-request vectors
    foreach (tbl[t]) begin
      ta[tbl[t].id] = tbl[t].a;
      tb[tbl[t].id] = tbl[t].b;
      tc[tbl[t].id] = tbl[t].c;
      h0 = hs_cnt;
      req_valid = N'(1) << tbl[t].id;
      step();
      req_valid = '0;
      k = 0;
      while (!rsp_valid && k < 20) begin
        step();
        k++;
      end
      check("single_latency", 64'(k), 64'(LAT + 1));
      check("single_id", 64'(rsp_id), 64'(tbl[t].id));
      check("single_sum", 64'(rsp_sum), 64'(tbl[t].s));
      check("single_grants", 64'(hs_cnt - h0), 64'(1));
      idle(2);
    end

    // All requesters valid continuously
    do_reset();
    hs_ids.delete();
    pop_ids.delete();
    pop_cyc.delete();
    for (int i = 0; i < N; i++) begin
      ta[i] = DW'(i * 10); tb[i] = DW'(i); tc[i] = -32'sd7;
    end
    req_valid = '1;
    for (int i = 0; i < 16; i++) step();
    idle(10);
    check("rr_grant_count", 64'(hs_ids.size()), 64'(16));
    check("rr_rsp_count", 64'(pop_ids.size()), 64'(16));
    if (hs_ids.size() == 16 && pop_ids.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("rr_grant_order", 64'(hs_ids[i]), 64'(i % N));
        check("rr_rsp_order", 64'(pop_ids[i]), 64'(i % N));
      end
      check("rr_back_to_back", 64'(pop_cyc[15] - pop_cyc[0]), 64'(15));
    end

    // Backpressure: credit limit then drain
    do_reset();
    rsp_ready = 1'b0;
    h0 = hs_cnt;
    p0 = pop_ids.size();
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      ta[1] = $urandom; tb[1] = $urandom; tc[1] = $urandom;
      step();
    end
    check("bp_issues", 64'(hs_cnt - h0), 64'(DEPTH));
    check("bp_ready_low", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ta[1] = $urandom; tb[1] = $urandom; tc[1] = $urandom;
      step();
    end
    idle(10);
    check("bp_no_loss", 64'(pop_ids.size() - p0), 64'(hs_cnt - h0));

    // Reset with 2 results in flight and 2 queued
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b1;
    p0 = pop_ids.size();
    idle(6);
    check("midrst_no_stale", 64'(pop_ids.size() - p0), 64'(0));
    hs_ids.delete();
    req_valid = '1;
    step();
    check("midrst_first_grant", 64'((hs_ids.size() > 0) ? hs_ids[0] : -1), 64'(0));
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        ta[r] = $urandom; tb[r] = $urandom; tc[r] = $urandom;
      end
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rsp_ready = 1'b1;
    idle(12);
    check("rand_drained", 64'(mq.size()), 64'(0));

`ifdef ASAT_ARB_STATS_EN
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 7; i++) step();
    rsp_ready = 1'b1;
    idle(10);
    req_valid = 4'b0100;
    step();
    step();
    idle(8);
    check("stat_grants2", 64'(stat_grants[2*16 +: 16]), 64'(6));
    check("stat_grants0", 64'(stat_grants[0 +: 16]), 64'(0));
    check("stat_stall", 64'(stat_stall), 64'(3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
